// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: pipeline-side requester signals and SRAM-like memory port bundled together
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_valid;
    logic                  inst_busy;
    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_valid;
    logic                  data_busy;
    logic                  mem_req;
    logic                  mem_wr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_rdata, inst_valid, inst_busy, data_rdata, data_valid, data_busy,
               mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_rdata, inst_valid, inst_busy, data_rdata, data_valid, data_busy,
               mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-outstanding memory port between fetch and load/store; ARB_FAIR_EN adds fetch anti-starvation
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA, DONE} state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_wr;
    logic [DATA_W/8-1:0]   r_mem_wstrb;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W-1:0]     r_inst_rdata;
    logic [DATA_W-1:0]     r_data_rdata;
    logic                  r_inst_valid;
    logic                  r_data_valid;
    logic                  w_fair_hit;
    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_is_d;
    logic                  w_in_addr;
    logic                  w_fin;

`ifdef ARB_FAIR_EN
    localparam int CW = $clog2(FAIR_LIMIT) + 1;
    logic [CW-1:0] r_fair;

    assign w_fair_hit = (r_fair == CW'(FAIR_LIMIT));

    // count data grants that made a waiting fetch wait; any fetch grant clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_fair <= '0;
        else if (r_state == IDLE)
            r_fair <= w_grant_i ? '0 : (w_grant_d && bus.inst_req) ? r_fair + 1'b1 : r_fair;
    end
`else
    logic w_unused_fair;
    assign w_unused_fair = (FAIR_LIMIT > 0);
    assign w_fair_hit    = 1'b0;
`endif

    assign w_grant_d = bus.data_req & ~(bus.inst_req & w_fair_hit);
    assign w_grant_i = bus.inst_req & ~w_grant_d;
    assign w_is_d    = (r_state == D_ADDR) || (r_state == D_DATA);
    assign w_in_addr = (r_state == I_ADDR) || (r_state == D_ADDR);
    assign w_fin     = (w_in_addr & bus.mem_addr_ok & bus.mem_data_ok) |
                       (((r_state == I_DATA) || (r_state == D_DATA)) & bus.mem_data_ok);

    // arbitration FSM with registered memory request fields, completion pulses and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wstrb  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= D_ADDR;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= bus.data_wr;
                        r_mem_wstrb <= bus.data_wr ? bus.data_wstrb : '0;
                        r_mem_addr  <= bus.data_addr;
                        r_mem_wdata <= bus.data_wdata;
                    end else if (w_grant_i) begin
                        r_state     <= I_ADDR;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_wstrb <= '0;
                        r_mem_addr  <= bus.inst_addr;
                        r_mem_wdata <= '0;
                    end
                end
                I_ADDR, D_ADDR: begin
                    if (bus.mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= bus.mem_data_ok ? DONE : (w_is_d ? D_DATA : I_DATA);
                    end
                end
                I_DATA, D_DATA: begin
                    if (bus.mem_data_ok)
                        r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_fin) begin
                if (w_is_d) begin
                    r_data_valid <= 1'b1;
                    if (!r_mem_wr)
                        r_data_rdata <= bus.mem_rdata;
                end else begin
                    r_inst_valid <= 1'b1;
                    r_inst_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_wstrb  = r_mem_wstrb;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_rdata = r_data_rdata;
    assign bus.inst_valid = r_inst_valid;
    assign bus.data_valid = r_data_valid;
    assign bus.inst_busy  = bus.inst_req & ~r_inst_valid;
    assign bus.data_busy  = bus.data_req & ~r_data_valid;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random requesters and memory against a transaction-level model of the arbiter
module tb_mem_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_LIMIT(LIM)) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // handshake phase of the single outstanding transaction: 0 free, 1 address, 2 response, 3 completion
    int            ph;
    bit            own_d;
    logic [AW-1:0] t_addr;
    logic          t_wr;
    logic [SW-1:0] t_strb;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] e_irdata;
    logic [DW-1:0] e_drdata;
    int            fair;
    int            p_i, p_d, p_ack;
    int            n_idone, n_ddone;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample_check();
        check("mem_req", bus.mem_req, ph == 1);
        if (ph == 1) begin
            check("mem_addr", bus.mem_addr, t_addr);
            check("mem_wr", bus.mem_wr, t_wr);
            check("mem_wstrb", bus.mem_wstrb, t_strb);
            if (t_wr)
                check("mem_wdata", bus.mem_wdata, t_wdata);
        end
        check("inst_valid", bus.inst_valid, ph == 3 && !own_d);
        check("data_valid", bus.data_valid, ph == 3 && own_d);
        check("inst_rdata", bus.inst_rdata, e_irdata);
        check("data_rdata", bus.data_rdata, e_drdata);
        check("inst_busy", bus.inst_busy, bus.inst_req && !(ph == 3 && !own_d));
        check("data_busy", bus.data_busy, bus.data_req && !(ph == 3 && own_d));
    endtask

    task automatic step();
        bit ao, dok;
        if (ph == 3) begin
            if (own_d) bus.data_req = 1'b0;
            else       bus.inst_req = 1'b0;
        end
        if (!bus.inst_req && $urandom_range(99) < p_i) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!bus.data_req && $urandom_range(99) < p_d) begin
            bus.data_req   = 1'b1;
            bus.data_wr    = 1'($urandom_range(1));
            bus.data_wstrb = bus.data_wr ? SW'($urandom_range(15, 1)) : '0;
            bus.data_addr  = $urandom;
            bus.data_wdata = $urandom;
        end
        ao  = 1'b0;
        dok = 1'b0;
        bus.mem_rdata = $urandom;
        case (ph)
            0: if (bus.data_req || bus.inst_req) begin
`ifdef ARB_FAIR_EN
                own_d = bus.data_req && !(bus.inst_req && fair == LIM);
                if (!own_d) fair = 0;
                else if (bus.inst_req) fair++;
`else
                own_d = bus.data_req;
`endif
                t_addr  = own_d ? bus.data_addr : bus.inst_addr;
                t_wr    = own_d && bus.data_wr;
                t_strb  = t_wr ? bus.data_wstrb : '0;
                t_wdata = bus.data_wdata;
                ph      = 1;
            end
            1: begin
                ao  = $urandom_range(99) < p_ack;
                dok = ao && ($urandom_range(3) == 0);
                ph  = ao ? (dok ? 3 : 2) : 1;
            end
            2: begin
                ao  = 1'($urandom_range(1));
                dok = $urandom_range(99) < p_ack;
                ph  = dok ? 3 : 2;
            end
            default: ph = 0;
        endcase
        bus.mem_addr_ok = ao;
        bus.mem_data_ok = dok;
        if (ph == 3) begin
            if (own_d) begin
                n_ddone++;
                if (!t_wr) e_drdata = bus.mem_rdata;
            end else begin
                n_idone++;
                e_irdata = bus.mem_rdata;
            end
        end
    endtask

    task automatic run(input int n, input int pi, input int pd, input int pa);
        p_i   = pi;
        p_d   = pd;
        p_ack = pa;
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_check();
            step();
        end
    endtask

    task automatic clear_inputs();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = '0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        ph       = 0;
        own_d    = 1'b0;
        fair     = 0;
        e_irdata = '0;
        e_drdata = '0;
    endtask

    initial begin
        bit found;
        int cnt_i0, cnt_d0;
        clear_inputs();
        n_idone = 0;
        n_ddone = 0;
        repeat (2) @(posedge clk);
        #1;
        sample_check();
        rst_n = 1'b1;
        run(400, 30, 30, 60);
        cnt_i0 = n_idone;
        cnt_d0 = n_ddone;
        run(400, 100, 100, 50);
        check("saturated_data_progress", n_ddone > cnt_d0, 1'b1);
`ifdef ARB_FAIR_EN
        check("fair_fetch_progress", n_idone > cnt_i0, 1'b1);
`endif
        run(300, 70, 70, 20);
        run(300, 50, 50, 100);
        p_d   = 100;
        p_i   = 40;
        p_ack = 30;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(posedge clk);
            #1;
            sample_check();
            if (ph == 2 && own_d) found = 1'b1;
            else step();
        end
        check("reset_window_found", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_data_valid", bus.data_valid, 1'b0);
        check("rst_inst_rdata", bus.inst_rdata, '0);
        check("rst_data_rdata", bus.data_rdata, '0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(400, 60, 60, 60);
        check("inst_completions_seen", n_idone > 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one SRAM-like memory port between the pipeline's instruction-fetch requester and its data (load/store) requester. It uses a single-outstanding request/address-ok/data-ok handshake toward memory. It returns per-requester busy signals that the hazard unit folds into stallF and the M-stage stall. It sits between the pipeline (pcF/instrF, aluoutM/writedataM/sig_write/readdataM) and the memory/bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
FAIR_LIMIT, 4, consecutive data grants allowed while an instruction request waits (used only with ARB_FAIR_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
inst_req  in  1  fetch request; held until inst_valid
inst_addr  in  ADDR_W  fetch address; stable while inst_req
inst_rdata  out  DATA_W  fetched word
inst_valid  out  1  one-cycle completion pulse for fetch
inst_busy  out  1  inst_req & ~inst_valid (combinational)
data_req  in  1  load/store request; held until data_valid
data_wr  in  1  1 = store
data_wstrb  in  DATA_W/8  byte strobes for store (sig_write)
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data
data_valid  out  1  one-cycle completion pulse for data
data_busy  out  1  data_req & ~data_valid (combinational)
mem_req  out  1  memory request
mem_wr  out  1  write
mem_wstrb  out  DATA_W/8  write strobes; 0 on reads
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_addr_ok  in  1  address accepted
mem_data_ok  in  1  response/ack
mem_rdata  in  DATA_W  read data

Behaviour:
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA, DONE. Reset and power-up state is IDLE.
- IDLE transitions:
  - data_req -> D_ADDR (data has priority).
  - else inst_req -> I_ADDR.
  - At grant, latch wr, wstrb, addr and wdata into mem_* registers. Force wstrb and wr to 0 for instruction grants.
- X_ADDR state:
  - mem_req=1; mem_* fields held stable.
  - mem_addr_ok=0 -> stay.
  - mem_addr_ok=1 & mem_data_ok=0 -> X_DATA.
  - mem_addr_ok=1 & mem_data_ok=1 -> DONE (zero-latency completion).
- X_DATA state: mem_req=0. mem_data_ok -> DONE; mem_addr_ok is ignored.
- Read data capture: on the completing mem_data_ok, capture mem_rdata into inst_rdata or data_rdata. Stores leave data_rdata unchanged.
- DONE state:
  - Exactly one of inst_valid/data_valid is 1 for this single cycle, matching the granted owner.
  - No grant is made in DONE, so a requester still holding req in its valid cycle is not re-served.
  - Next state is IDLE.
- Minimum latency: req seen in IDLE at t, mem_req at t+1, valid at t+3 (t+2 with zero-latency memory).
- Read data outputs hold their value until the next completion of the same requester.
- Only one transaction is outstanding at a time. Requests arriving while not in IDLE wait, and their busy flag stays high.
- Reset values:
  - mem_req/mem_wr/inst_valid/data_valid = 0.
  - mem_wstrb/mem_addr/mem_wdata/inst_rdata/data_rdata = 0.
- Reset asserted mid-transaction: return to IDLE asynchronously and drop mem_req immediately. Memory is reset on the same rst, so no stale data_ok is tracked.
- A data_req that rises while an instruction transaction is in flight is served after DONE; the instruction transaction is not aborted.

Optional Feature:
Macro ARB_FAIR_EN.
- Defined:
  - A counter (width clog2(FAIR_LIMIT)+1, reset 0) increments on each data grant made while inst_req=1.
  - When the counter equals FAIR_LIMIT, the next IDLE grant goes to inst_req even if data_req=1; the counter clears on any instruction grant.
- Undefined: strict data priority, no counter; instruction fetch may starve while data_req stays asserted.

Test Plan:
1. Fetch: inst_req=1, inst_addr=0xBFC00000 at t; addr_ok at t+1; data_ok at t+3 with rdata 0x24010001 -> mem_addr=0xBFC00000, mem_wr=0, mem_wstrb=0; inst_valid=1 only at t+4; inst_rdata=0x24010001; inst_busy high t..t+3.
2. Simultaneous: data store (addr 0x80000010, wdata 0x12345678, wstrb 0xF) and inst_req both at t -> data served first with mem_wr=1, mem_wstrb=0xF; then fetch; inst_busy high until its own valid; data_rdata unchanged.
3. Backpressure: mem_addr_ok held 0 for 5 cycles -> mem_req=1 with identical mem_addr/mem_wdata for all 5 cycles; exactly one transaction completes.
4. Zero-latency memory: addr_ok=data_ok=1 in the first ADDR cycle, load from 0x80000020 returning 0xDEADBEEF -> data_valid at t+2, data_rdata=0xDEADBEEF.
5. Reset: rst=0 during D_DATA -> mem_req=0 and both valids 0 immediately; after rst=1, a new inst_req completes normally with the minimum latency.
6. Fairness: data_req and inst_req held continuously -> with ARB_FAIR_EN and FAIR_LIMIT=4, the fetch is granted after the 4th data completion; without the macro, no fetch grant occurs while data_req=1.
